alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU/compare datapath between two requesters, A and B, using round-robin arbitration.
- Each requester issues an operation: two operands, a 4-bit ALU control and a 3-bit compare code.
- The block latches the granted operation, drives the shared ALU for ALU_LAT cycles, samples the result and returns it on one response channel tagged with the requester id.
- It sits between the ALU and the two issuing units (e.g. the execute stage and a branch unit).

Parameters:
- ALU_LAT, 1, cycles the ALU inputs are held before the result is sampled. Legal range 1..15.
- WIDTH, 32, operand and result width.

Ports:
- clk_i  in  1  clock; all logic updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- a_valid_i / b_valid_i  in  1  request valid, A / B.
- a_ready_o / b_ready_o  out  1  request accepted this cycle.
- a_src1_i, a_src2_i / b_src1_i, b_src2_i  in  WIDTH  operands.
- a_ctrl_i / b_ctrl_i  in  4  ALU operation select.
- a_comp_i / b_comp_i  in  3  compare code: 0 lt, 1 gt, 2 le, 3 ge, 6 eq, others ne.
- alu_src1_o, alu_src2_o  out  WIDTH  shared ALU operands.
- alu_ctrl_o  out  4  shared ALU control.
- alu_comp_o  out  3  shared compare code.
- alu_result_i  in  WIDTH  ALU result.
- alu_zero_i, alu_cout_i, alu_overflow_i  in  1  ALU flags.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_id_o  out  1  0 = A, 1 = B.
- rsp_result_o  out  WIDTH  sampled ALU result.
- rsp_zero_o, rsp_cout_o, rsp_overflow_o  out  1  sampled flags.
- busy_o  out  1  high in EXEC or RESP.

Behaviour:
- Clock/reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset state: state=IDLE; last_grant=B, so A wins the first tie; lat_cnt=0; operand, result and flag registers=0. All outputs are 0 during and after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
- IDLE, accept:
  - x_ready_o=1 combinationally for the granted requester only. The ready depends on the valid inputs and on last_grant, but never on the operands.
  - On accept: latch src1, src2, ctrl, comp and id; set last_grant=id; set lat_cnt=ALU_LAT; go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - alu_*_o are driven from the latched registers, constant for exactly ALU_LAT cycles.
  - lat_cnt decrements each cycle.
  - In the cycle where lat_cnt==1: register alu_result_i and the three flags, then go to RESP.
  - x_ready_o=0 in this state.
- RESP:
  - rsp_valid_o=1. rsp_id, result and flags are held stable until rsp_ready_i=1.
  - On handshake: go to IDLE.
  - No new accept happens in the handshake cycle.
- alu_*_o are 0 in IDLE and in RESP. This keeps toggling off the shared ALU.
- Latency: accept edge at cycle T; rsp_valid_o rises at T+ALU_LAT+1. Minimum spacing between accepts is ALU_LAT+2 cycles.
- Requester inputs changing after accept have no effect on the operation in flight.
- ALU inputs changing while in RESP have no effect on the held response.
- The compare code passes through unmodified; the block does not interpret result bits.
- Reset mid-EXEC or mid-RESP aborts the operation: no response is produced, and last_grant returns to B.
- busy_o = (state != IDLE).
- A valid request may be dropped by the requester before it is granted; there is no penalty.

Test Plan:
1. Reset: rst_i=1 for 2 cycles with a_valid_i=b_valid_i=1 -> a_ready_o=b_ready_o=0, rsp_valid_o=0, alu_*_o=0, busy_o=0. On the first cycle after reset, a_ready_o=1.
2. Single op, ALU_LAT=1: A sends src1=5, src2=7, comp=0; ALU stub returns result=1, zero=0; rsp_ready_i=1 -> rsp_valid_o=1 at T+2 with rsp_id_o=0, rsp_result_o=1. The next accept occurs no earlier than T+3.
3. Fairness: A and B valid continuously for 4 ops -> grant order A, B, A, B. Each response id matches its grant. alu_src1_o equals the winner's src1.
4. Backpressure: after a B op with result 0xFFFFFFFF, hold rsp_ready_i=0 for 5 cycles while the stub changes alu_result_i -> response stays at 0xFFFFFFFF with rsp_id_o=1, both ready outputs stay 0, alu_*_o=0.
5. Latency/isolation: ALU_LAT=4, A accepted with src1=0x10; change a_src1_i to 0x20 on the next cycle -> alu_src1_o=0x10 for exactly 4 cycles, rsp_valid_o rises at T+5.
6. Abort: ALU_LAT=4, assert rst_i for 1 cycle during the 2nd EXEC cycle of a B op -> no response. Afterwards, with A and B both valid, A is granted first.

Source files
------------

// File: rtl/alu_share_if.sv
// Requester, shared-ALU and response signals of the ALU share arbiter.
// slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_share_if #(parameter int WIDTH = 32);
  logic             a_valid_i, b_valid_i;
  logic             a_ready_o, b_ready_o;
  logic [WIDTH-1:0] a_src1_i, a_src2_i, b_src1_i, b_src2_i;
  logic [3:0]       a_ctrl_i, b_ctrl_i;
  logic [2:0]       a_comp_i, b_comp_i;
  logic [WIDTH-1:0] alu_src1_o, alu_src2_o;
  logic [3:0]       alu_ctrl_o;
  logic [2:0]       alu_comp_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_zero_i, alu_cout_i, alu_overflow_i;
  logic             rsp_valid_o, rsp_ready_i, rsp_id_o;
  logic [WIDTH-1:0] rsp_result_o;
  logic             rsp_zero_o, rsp_cout_o, rsp_overflow_o;
  logic             busy_o;

  modport slave (
    input  a_valid_i, b_valid_i, a_src1_i, a_src2_i, b_src1_i, b_src2_i,
           a_ctrl_i, b_ctrl_i, a_comp_i, b_comp_i,
           alu_result_i, alu_zero_i, alu_cout_i, alu_overflow_i, rsp_ready_i,
    output a_ready_o, b_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_comp_o,
           rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_cout_o,
           rsp_overflow_o, busy_o
  );

  modport master (
    output a_valid_i, b_valid_i, a_src1_i, a_src2_i, b_src1_i, b_src2_i,
           a_ctrl_i, b_ctrl_i, a_comp_i, b_comp_i,
           alu_result_i, alu_zero_i, alu_cout_i, alu_overflow_i, rsp_ready_i,
    input  a_ready_o, b_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_comp_o,
           rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_cout_o,
           rsp_overflow_o, busy_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between requesters A and B: latch the winner,
// hold ALU inputs for ALU_LAT cycles, return the sampled result tagged by id.
module alu_share_arbiter #(
  parameter int ALU_LAT = 1,
  parameter int WIDTH   = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q;
  logic             last_q, id_q;
  logic [3:0]       lat_q;
  logic [WIDTH-1:0] s1_q, s2_q, res_q;
  logic [3:0]       ctrl_q;
  logic [2:0]       comp_q;
  logic             zero_q, cout_q, ovf_q;
  logic             gnt_a, gnt_b, exec;

  // last_q: 0 = A won last, 1 = B won last; the other side wins a tie.
  assign gnt_a = bus.a_valid_i & (~bus.b_valid_i | last_q);
  assign gnt_b = bus.b_valid_i & (~bus.a_valid_i | ~last_q);
  assign exec  = (state_q == EXEC);

  assign bus.a_ready_o      = (state_q == IDLE) & ~rst_i & gnt_a;
  assign bus.b_ready_o      = (state_q == IDLE) & ~rst_i & gnt_b;
  assign bus.alu_src1_o     = exec ? s1_q   : '0;
  assign bus.alu_src2_o     = exec ? s2_q   : '0;
  assign bus.alu_ctrl_o     = exec ? ctrl_q : '0;
  assign bus.alu_comp_o     = exec ? comp_q : '0;
  assign bus.rsp_valid_o    = (state_q == RESP);
  assign bus.rsp_id_o       = id_q;
  assign bus.rsp_result_o   = res_q;
  assign bus.rsp_zero_o     = zero_q;
  assign bus.rsp_cout_o     = cout_q;
  assign bus.rsp_overflow_o = ovf_q;
  assign bus.busy_o         = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      lat_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      ctrl_q  <= '0;
      comp_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt_a | gnt_b) begin
          id_q    <= gnt_b;
          last_q  <= gnt_b;
          s1_q    <= gnt_b ? bus.b_src1_i : bus.a_src1_i;
          s2_q    <= gnt_b ? bus.b_src2_i : bus.a_src2_i;
          ctrl_q  <= gnt_b ? bus.b_ctrl_i : bus.a_ctrl_i;
          comp_q  <= gnt_b ? bus.b_comp_i : bus.a_comp_i;
          lat_q   <= 4'(ALU_LAT);
          state_q <= EXEC;
        end
        EXEC: if (lat_q == 4'd1) begin
          res_q   <= bus.alu_result_i;
          zero_q  <= bus.alu_zero_i;
          cout_q  <= bus.alu_cout_i;
          ovf_q   <= bus.alu_overflow_i;
          lat_q   <= '0;
          state_q <= RESP;
        end else begin
          lat_q   <= lat_q - 4'd1;
        end
        RESP: if (bus.rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: u1 (ALU_LAT=1) covers reset, fairness, single ops and
// backpressure; u4 (ALU_LAT=4) covers latency, input isolation and abort.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst1, rst4;
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_share_if #(.WIDTH(32)) if1 ();
  alu_share_if #(.WIDTH(32)) if4 ();

  alu_share_arbiter #(.ALU_LAT(1), .WIDTH(32)) u1 (.clk_i(clk), .rst_i(rst1), .bus(if1.slave));
  alu_share_arbiter #(.ALU_LAT(4), .WIDTH(32)) u4 (.clk_i(clk), .rst_i(rst4), .bus(if4.slave));

  typedef struct {
    logic        av, bv;
    logic [31:0] as1, bs1;
    logic [2:0]  acomp, bcomp;
    logic [31:0] res;
    logic        ez;
    logic        exp_id;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    if1.a_valid_i = 0; if1.b_valid_i = 0; if1.a_src1_i = 0; if1.a_src2_i = 0;
    if1.b_src1_i = 0; if1.b_src2_i = 0; if1.a_ctrl_i = 0; if1.b_ctrl_i = 0;
    if1.a_comp_i = 0; if1.b_comp_i = 0; if1.alu_result_i = 0; if1.alu_zero_i = 0;
    if1.alu_cout_i = 0; if1.alu_overflow_i = 0; if1.rsp_ready_i = 1;
    if4.a_valid_i = 0; if4.b_valid_i = 0; if4.a_src1_i = 0; if4.a_src2_i = 0;
    if4.b_src1_i = 0; if4.b_src2_i = 0; if4.a_ctrl_i = 0; if4.b_ctrl_i = 0;
    if4.a_comp_i = 0; if4.b_comp_i = 0; if4.alu_result_i = 0; if4.alu_zero_i = 0;
    if4.alu_cout_i = 0; if4.alu_overflow_i = 0; if4.rsp_ready_i = 1;
    rst1 = 1; rst4 = 1;

    //            av bv  as1 bs1  acomp bcomp res            ez exp_id
    vecs[0] = '{1, 1, 32'd1,  32'd100, 3'd0, 3'd6, 32'd2,          1'b0, 1'b0};
    vecs[1] = '{1, 1, 32'd11, 32'd200, 3'd1, 3'd2, 32'd0,          1'b1, 1'b1};
    vecs[2] = '{1, 1, 32'd12, 32'd300, 3'd3, 3'd4, 32'h7fff_ffff,  1'b0, 1'b0};
    vecs[3] = '{1, 1, 32'd13, 32'd400, 3'd5, 3'd7, 32'h8000_0000,  1'b0, 1'b1};
    vecs[4] = '{1, 0, 32'd5,  32'd500, 3'd0, 3'd1, 32'd1,          1'b0, 1'b0};
    vecs[5] = '{0, 1, 32'd15, 32'd600, 3'd2, 3'd3, 32'd43,         1'b0, 1'b1};
    vecs[6] = '{0, 1, 32'd16, 32'd700, 3'd2, 3'd6, 32'd44,         1'b1, 1'b1};

    // Reset with both requesters valid
    if1.a_valid_i = 1; if1.b_valid_i = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_a_ready", if1.a_ready_o, 0);
      chk("rst_b_ready", if1.b_ready_o, 0);
      chk("rst_rsp_valid", if1.rsp_valid_o, 0);
      chk("rst_alu_src1", if1.alu_src1_o, 0);
      chk("rst_alu_ctrl", if1.alu_ctrl_o, 0);
      chk("rst_busy", if1.busy_o, 0);
      chk("rst_rsp_result", if1.rsp_result_o, 0);
    end
    rst1 = 0;

    for (int i = 0; i < 7; i++) begin
      if1.a_valid_i = vecs[i].av; if1.b_valid_i = vecs[i].bv;
      if1.a_src1_i = vecs[i].as1; if1.a_src2_i = 32'd7; if1.a_ctrl_i = 4'd1; if1.a_comp_i = vecs[i].acomp;
      if1.b_src1_i = vecs[i].bs1; if1.b_src2_i = 32'd3; if1.b_ctrl_i = 4'd2; if1.b_comp_i = vecs[i].bcomp;
      if1.rsp_ready_i = 1;
      #1;
      chk($sformatf("v%0d_a_ready", i), if1.a_ready_o, !vecs[i].exp_id);
      chk($sformatf("v%0d_b_ready", i), if1.b_ready_o, vecs[i].exp_id);
      step();
      chk($sformatf("v%0d_alu_src1", i), if1.alu_src1_o, vecs[i].exp_id ? vecs[i].bs1 : vecs[i].as1);
      chk($sformatf("v%0d_alu_src2", i), if1.alu_src2_o, vecs[i].exp_id ? 32'd3 : 32'd7);
      chk($sformatf("v%0d_alu_ctrl", i), if1.alu_ctrl_o, vecs[i].exp_id ? 4'd2 : 4'd1);
      chk($sformatf("v%0d_alu_comp", i), if1.alu_comp_o, vecs[i].exp_id ? vecs[i].bcomp : vecs[i].acomp);
      chk($sformatf("v%0d_exec_ready", i), {if1.a_ready_o, if1.b_ready_o}, 0);
      chk($sformatf("v%0d_busy", i), if1.busy_o, 1);
      if1.alu_result_i = vecs[i].res; if1.alu_zero_i = vecs[i].ez; if1.alu_cout_i = 1;
      if1.a_src1_i = 32'hdead_beef; if1.b_src1_i = 32'hdead_beef;
      step();
      chk($sformatf("v%0d_rsp_valid", i), if1.rsp_valid_o, 1);
      chk($sformatf("v%0d_rsp_id", i), if1.rsp_id_o, vecs[i].exp_id);
      chk($sformatf("v%0d_rsp_result", i), if1.rsp_result_o, vecs[i].res);
      chk($sformatf("v%0d_rsp_zero", i), if1.rsp_zero_o, vecs[i].ez);
      chk($sformatf("v%0d_rsp_cout", i), if1.rsp_cout_o, 1);
      chk($sformatf("v%0d_resp_alu_src1", i), if1.alu_src1_o, 0);
      chk($sformatf("v%0d_resp_ready", i), {if1.a_ready_o, if1.b_ready_o}, 0);
      if1.alu_result_i = 0; if1.alu_zero_i = 0; if1.alu_cout_i = 0;
      step();
      chk($sformatf("v%0d_idle_busy", i), if1.busy_o, 0);
    end

    // Backpressure on a B response while the ALU result keeps moving
    if1.a_valid_i = 0; if1.b_valid_i = 1; if1.b_src1_i = 32'h77;
    #1;
    chk("bp_b_ready", if1.b_ready_o, 1);
    step();
    if1.alu_result_i = 32'hffff_ffff; if1.a_valid_i = 1;
    step();
    if1.rsp_ready_i = 0;
    for (int k = 0; k < 5; k++) begin
      if1.alu_result_i = 32'h1111 * k; if1.alu_cout_i = k[0];
      #1;
      chk("bp_rsp_valid", if1.rsp_valid_o, 1);
      chk("bp_rsp_result", if1.rsp_result_o, 32'hffff_ffff);
      chk("bp_rsp_id", if1.rsp_id_o, 1);
      chk("bp_ready", {if1.a_ready_o, if1.b_ready_o}, 0);
      chk("bp_alu_src1", if1.alu_src1_o, 0);
      step();
    end
    if1.rsp_ready_i = 1;
    step();
    chk("bp_release_busy", if1.busy_o, 0);
    if1.a_valid_i = 0; if1.b_valid_i = 0;

    // ALU_LAT=4: latency and isolation from requester changes
    rst4 = 0;
    if4.a_valid_i = 1; if4.a_src1_i = 32'h10; if4.a_src2_i = 32'h1;
    #1;
    chk("l4_a_ready", if4.a_ready_o, 1);
    step();
    if4.a_src1_i = 32'h20; if4.a_valid_i = 0; if4.alu_result_i = 32'h30;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("l4_alu_src1_c%0d", k), if4.alu_src1_o, 32'h10);
      chk($sformatf("l4_no_rsp_c%0d", k), if4.rsp_valid_o, 0);
      step();
    end
    chk("l4_rsp_valid", if4.rsp_valid_o, 1);
    chk("l4_rsp_result", if4.rsp_result_o, 32'h30);
    chk("l4_rsp_id", if4.rsp_id_o, 0);
    chk("l4_resp_alu_src1", if4.alu_src1_o, 0);
    step();
    chk("l4_idle_busy", if4.busy_o, 0);

    // Abort a B op in its second EXEC cycle
    if4.b_valid_i = 1; if4.b_src1_i = 32'h55;
    #1;
    chk("ab_b_ready", if4.b_ready_o, 1);
    step();
    if4.b_valid_i = 0;
    step();
    rst4 = 1;
    step();
    rst4 = 0;
    for (int k = 0; k < 6; k++) begin
      chk("ab_no_rsp", if4.rsp_valid_o, 0);
      chk("ab_busy", if4.busy_o, 0);
      step();
    end
    // Abort an A op too: last_grant must fall back to B, so A still wins
    if4.a_valid_i = 1;
    #1;
    chk("ab2_a_ready", if4.a_ready_o, 1);
    step();
    if4.a_valid_i = 0;
    step();
    rst4 = 1;
    step();
    rst4 = 0;
    chk("ab2_no_rsp", if4.rsp_valid_o, 0);
    if4.a_valid_i = 1; if4.b_valid_i = 1;
    #1;
    chk("ab2_tie_a_ready", if4.a_ready_o, 1);
    chk("ab2_tie_b_ready", if4.b_ready_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
